// File: rtl/uart_pkg.sv
// uart_pkg: shared UART clocking constants and feeder state encoding
package uart_pkg;
  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int BAUD = 115200;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} feeder_state_e;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: host write port, FIFO status and transmitter handshake of the feeder
interface uart_tx_feeder_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  logic wr_en;
  logic [WIDTH-1:0] wr_data;
  logic full;
  logic empty;
  logic [$clog2(DEPTH):0] count;
  logic overflow;
  logic tx_busy;
  logic tx_start;
  logic [WIDTH-1:0] tx_data;
  modport master(
    output wr_en, wr_data, tx_busy,
    input full, empty, count, overflow, tx_start, tx_data
  );
  modport slave(
    input wr_en, wr_data, tx_busy,
    output full, empty, count, overflow, tx_start, tx_data
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: circular-buffer byte FIFO with registered count, full, empty and overflow flags
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic [WIDTH-1:0] push_data,
  input logic pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_nxt,
  output logic full,
  output logic empty,
  output logic overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, overflow_q, overflow_d, do_push;
  always_comb begin
    do_push = push && !full_q;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(pop);
    full_d = count_d == (AW+1)'(DEPTH);
    empty_d = count_d == '0;
    overflow_d = push && full_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end
  assign pop_data = mem[rd_ptr_q];
  assign count = count_q;
  assign count_nxt = count_d;
  assign full = full_q;
  assign empty = empty_q;
  assign overflow = overflow_q;
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and launches them one at a time into the UART transmitter
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int SETUP_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  uart_tx_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETUP_CYCLES + 1);
  feeder_state_e state_q, state_d;
  logic [SW-1:0] setup_q, setup_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d, rd_data;
  logic tx_start_q, tx_start_d, empty_q, empty_d, pop, fifo_empty, full, overflow;
  logic [AW:0] count, count_nxt;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(bus.wr_en),
    .push_data(bus.wr_data),
    .pop(pop),
    .pop_data(rd_data),
    .count(count),
    .count_nxt(count_nxt),
    .full(full),
    .empty(fifo_empty),
    .overflow(overflow)
  );
  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    tx_data_d = tx_data_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop = 1'b1;
        tx_data_d = rd_data;
        setup_d = SW'(SETUP_CYCLES);
        state_d = LOAD;
      end
      LOAD: begin
        setup_d = setup_q - SW'(1);
        state_d = setup_q == SW'(1) ? START : LOAD;
      end
      START: state_d = WAIT_BUSY;
      WAIT_BUSY: state_d = bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
    tx_start_d = state_d == START;
    empty_d = (count_nxt == '0) && (state_d == IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      setup_q <= '0;
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      setup_q <= setup_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      empty_q <= empty_d;
    end
  end
  assign bus.tx_data = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.empty = empty_q;
  assign bus.full = full;
  assign bus.count = count;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: randomized scoreboard bench for the UART transmit feeder
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int SETUP = 2;
  localparam int BIT_CYC = 4;
  localparam int FRAME = 10 * BIT_CYC;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic model_busy = 1'b0;
  logic hold_busy = 1'b0;
  int tests = 0;
  int fails = 0;
  int starts = 0;
  int doubles = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seen_q[$];
  uart_tx_feeder_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();
  uart_tx_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SETUP_CYCLES(SETUP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #10 clk = ~clk;
  assign bus.tx_busy = model_busy | hold_busy;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int left = 0;
    logic prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_start) begin
        seen_q.push_back(bus.tx_data);
        starts++;
        if (prev) doubles++;
        model_busy = 1'b1;
        left = FRAME;
      end else if (left > 0) begin
        left--;
        if (left == 0) model_busy = 1'b0;
      end
      prev = bus.tx_start;
    end
  end
  task automatic wait_drain(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (seen_q.size() >= n && bus.empty && !bus.tx_busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask
  task automatic test_reset();
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    repeat (3) tick();
    tests++;
    if ({bus.count, bus.full, bus.empty, bus.overflow, bus.tx_start, bus.tx_data} !== {5'd0, 4'b0100, 8'h00}) begin
      fails++;
      $display("FAIL reset_in got cnt=%0d full=%b empty=%b ovf=%b start=%b data=%h want 0 0 1 0 0 00",
               bus.count, bus.full, bus.empty, bus.overflow, bus.tx_start, bus.tx_data);
    end
    rst = 1'b0;
    repeat (2) tick();
    tests++;
    if ({bus.count, bus.full, bus.empty, bus.overflow, bus.tx_start, bus.tx_data} !== {5'd0, 4'b0100, 8'h00}) begin
      fails++;
      $display("FAIL reset_out got cnt=%0d full=%b empty=%b ovf=%b start=%b data=%h want 0 0 1 0 0 00",
               bus.count, bus.full, bus.empty, bus.overflow, bus.tx_start, bus.tx_data);
    end
  endtask
  task automatic test_single();
    bit ok;
    seen_q.delete();
    exp_q = {8'hA5};
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0;
    tests++;
    if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin
      fails++;
      $display("FAIL single_n count=%0d empty=%b want 1 0", bus.count, bus.empty);
    end
    tick();
    tests++;
    if (bus.tx_data !== 8'hA5 || bus.count !== 5'd0 || bus.tx_start !== 1'b0) begin
      fails++;
      $display("FAIL single_n1 data=%h count=%0d start=%b want a5 0 0", bus.tx_data, bus.count, bus.tx_start);
    end
    tick();
    tests++;
    if (bus.tx_start !== 1'b0) begin
      fails++;
      $display("FAIL single_n2 start=%b want 0", bus.tx_start);
    end
    tick();
    tests++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5) begin
      fails++;
      $display("FAIL single_n3 start=%b data=%h want 1 a5", bus.tx_start, bus.tx_data);
    end
    tick();
    tests++;
    if (bus.tx_start !== 1'b0) begin
      fails++;
      $display("FAIL single_n4 start=%b want 0", bus.tx_start);
    end
    repeat (10) tick();
    tests++;
    if (bus.tx_data !== 8'hA5 || bus.empty !== 1'b0 || bus.tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL single_hold data=%h empty=%b busy=%b want a5 0 1", bus.tx_data, bus.empty, bus.tx_busy);
    end
    wait_drain(1, ok);
    tests++;
    if (!ok || seen_q.size() != 1 || seen_q[0] !== 8'hA5) begin
      fails++;
      $display("FAIL single_line ok=%b seen=%0d want 1 byte a5", ok, seen_q.size());
    end
    tick();
    tests++;
    if (bus.empty !== 1'b1) begin
      fails++;
      $display("FAIL single_empty empty=%b want 1", bus.empty);
    end
  endtask
  task automatic test_push_pop();
    bit ok;
    seen_q.delete();
    exp_q = {8'h11, 8'h22};
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h11;
    tick();
    bus.wr_data = 8'h22;
    tick();
    bus.wr_en = 1'b0;
    tests++;
    if (bus.count !== 5'd1 || bus.tx_data !== 8'h11) begin
      fails++;
      $display("FAIL pushpop_same count=%0d data=%h want 1 11", bus.count, bus.tx_data);
    end
    wait_drain(2, ok);
    tests++;
    if (!ok || seen_q.size() != 2) begin
      fails++;
      $display("FAIL pushpop_drain ok=%b seen=%0d want 2", ok, seen_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      tests++;
      if (seen_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL pushpop_byte%0d got %h want %h", i, seen_q[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_burst();
    bit ok;
    int s0 = starts;
    seen_q.delete();
    exp_q.delete();
    for (int i = 1; i <= 16; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      exp_q.push_back(8'(i));
      tick();
    end
    bus.wr_en = 1'b0;
    tests++;
    if (bus.count !== 5'd15 || bus.full !== 1'b0) begin
      fails++;
      $display("FAIL burst_level count=%0d full=%b want 15 0", bus.count, bus.full);
    end
    wait_drain(16, ok);
    tests++;
    if (!ok || seen_q.size() != 16 || starts - s0 != 16 || doubles != 0) begin
      fails++;
      $display("FAIL burst_starts ok=%b seen=%0d starts=%0d doubles=%0d want 16 16 0", ok, seen_q.size(), starts - s0, doubles);
    end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      tests++;
      if (seen_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL burst_byte%0d got %h want %h", i, seen_q[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_overflow();
    bit ok;
    seen_q.delete();
    exp_q.delete();
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 18; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = i == 17 ? 8'hEE : 8'($urandom_range(0, 8'hED));
      if (i < 17) exp_q.push_back(bus.wr_data);
      tick();
      if (i == 15) begin
        tests++;
        if (bus.full !== 1'b0 || bus.count !== 5'd15) begin
          fails++;
          $display("FAIL ovf_16th full=%b count=%0d want 0 15", bus.full, bus.count);
        end
      end
      if (i == 16) begin
        tests++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
          fails++;
          $display("FAIL ovf_17th full=%b count=%0d ovf=%b want 1 16 0", bus.full, bus.count, bus.overflow);
        end
      end
    end
    bus.wr_en = 1'b0;
    tests++;
    if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
      fails++;
      $display("FAIL ovf_pulse ovf=%b count=%0d want 1 16", bus.overflow, bus.count);
    end
    tick();
    tests++;
    if (bus.overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_single ovf=%b want 0", bus.overflow);
    end
    hold_busy = 1'b0;
    wait_drain(17, ok);
    tests++;
    if (!ok || seen_q.size() != 17) begin
      fails++;
      $display("FAIL ovf_drain ok=%b seen=%0d want 17", ok, seen_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      tests++;
      if (seen_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL ovf_byte%0d got %h want %h", i, seen_q[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_wrap();
    bit ok;
    int pushed = 0;
    int guard = 0;
    seen_q.delete();
    exp_q.delete();
    while (pushed < 40 && guard < 20000) begin
      bit go = (pushed - seen_q.size() < 14) && ($urandom_range(0, 3) != 0);
      guard++;
      bus.wr_en = go;
      bus.wr_data = 8'(pushed);
      tick();
      if (go) begin
        exp_q.push_back(8'(pushed));
        pushed++;
        tests++;
        if (bus.full !== 1'b0) begin
          fails++;
          $display("FAIL wrap_full at push %0d full=%b want 0", pushed, bus.full);
        end
      end
    end
    bus.wr_en = 1'b0;
    wait_drain(40, ok);
    tests++;
    if (!ok || pushed != 40 || seen_q.size() != 40) begin
      fails++;
      $display("FAIL wrap_drain ok=%b pushed=%0d seen=%0d want 40 40", ok, pushed, seen_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      tests++;
      if (seen_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL wrap_byte%0d got %h want %h", i, seen_q[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_reset_mid();
    bit ok;
    seen_q.delete();
    exp_q = {8'h50, 8'h3C};
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h50 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    repeat (5) tick();
    tests++;
    if (bus.count !== 5'd5) begin
      fails++;
      $display("FAIL rstmid_queued count=%0d want 5", bus.count);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_clear count=%0d empty=%b start=%b data=%h want 0 1 0 00",
               bus.count, bus.empty, bus.tx_start, bus.tx_data);
    end
    tick();
    rst = 1'b0;
    hold_busy = 1'b0;
    for (int c = 0; c < 500 && bus.tx_busy; c++) tick();
    repeat (3) tick();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0;
    wait_drain(2, ok);
    tests++;
    if (!ok || seen_q.size() != 2) begin
      fails++;
      $display("FAIL rstmid_drain ok=%b seen=%0d want 2", ok, seen_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
      tests++;
      if (seen_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rstmid_byte%0d got %h want %h", i, seen_q[i], exp_q[i]);
      end
    end
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_push_pop();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
